// File: rtl/mem_tag_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_tag_responder
// Brief    : Cycle-level tagged memory responder for the data-memory bus.
//            64-bit backing store, stores merged at the accepting edge,
//            loads snapshotted at acceptance and returned LATENCY cycles
//            later through an in-order tagged return queue.
// Options  : MEM_RESP_STALL_EN - when defined, a free-running 2-bit counter
//            forces a rejected response every fourth cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_tag_responder #(
  parameter int MEM_LINES = 8192,
  parameter int LATENCY   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Dmem_command,
  input  logic [15:0] Dmem_addr,
  input  logic [1:0]  Dmem_size,
  input  logic [63:0] Dmem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int         c_idx_w     = $clog2(MEM_LINES);
  localparam int         c_depth     = 15;
  localparam logic [3:0] c_cd_init   = 4'(LATENCY - 1);
  localparam logic [1:0] c_cmd_load  = 2'd1;
  localparam logic [1:0] c_cmd_store = 2'd2;
  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;

  // Backing store; reset never touches it.
  logic [63:0] r_mem [MEM_LINES];

  // Return queue payload (slot tag, snapshotted line, countdown).
  logic [3:0]  r_fifo_tag  [c_depth];
  logic [63:0] r_fifo_data [c_depth];
  logic [3:0]  r_fifo_cd   [c_depth];
  logic [3:0]  r_wr_ptr;
  logic [3:0]  r_rd_ptr;
  logic [3:0]  r_count;

  logic [3:0]  r_next_tag;
  logic [15:0] r_held;       // bit t set while tag t belongs to an outstanding load
  logic [3:0]  r_ret_tag;
  logic [63:0] r_ret_data;

  logic [c_idx_w-1:0] w_line_idx;
  logic [63:0]        w_rd_line;
  logic               w_stall;
  logic               w_is_load;
  logic               w_is_store;
  logic               w_accept;
  logic               w_push;
  logic               w_direct;
  logic               w_pop;
  logic [7:0]         w_be;
  logic [63:0]        w_wdata;
  logic [15:0]        w_push_mask;
  logic [15:0]        w_pop_mask;

  function automatic logic [3:0] f_ptr_inc(input logic [3:0] p);
    return (p == 4'(c_depth - 1)) ? 4'd0 : p + 4'd1;
  endfunction

  assign w_line_idx = Dmem_addr[3 +: c_idx_w];
  assign w_rd_line  = r_mem[w_line_idx];
  assign w_is_load  = (Dmem_command == c_cmd_load);
  assign w_is_store = (Dmem_command == c_cmd_store);

`ifdef MEM_RESP_STALL_EN
  logic [1:0] r_stall_cnt;

  // Free-running retry-exercise counter; stalls when it reads 3.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 2'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 2'd1;
    end
  end

  assign w_stall = (r_stall_cnt == 2'd3);
`else
  assign w_stall = 1'b0;
`endif

  // A held next_tag blocks acceptance; with a full queue this is always true.
  assign w_accept = reset && (w_is_load || w_is_store) && !r_held[r_next_tag] && !w_stall;
  assign mem2proc_response = w_accept ? r_next_tag : 4'd0;

  // LATENCY of 1 returns straight from the accepting edge, bypassing the queue.
  assign w_push   = w_accept && w_is_load && (LATENCY > 1);
  assign w_direct = w_accept && w_is_load && (LATENCY == 1);
  assign w_pop    = (r_count != 4'd0) && (r_fifo_cd[r_rd_ptr] == 4'd1);

  assign w_push_mask = w_push ? (16'd1 << r_next_tag) : 16'd0;
  assign w_pop_mask  = w_pop  ? (16'd1 << r_fifo_tag[r_rd_ptr]) : 16'd0;

  // Byte-lane enables and replicated write data; low address bits force alignment.
  always_comb begin
    w_be    = 8'hFF;
    w_wdata = Dmem_data;
    case (Dmem_size)
      c_size_byte: begin
        w_be    = 8'h01 << Dmem_addr[2:0];
        w_wdata = {8{Dmem_data[7:0]}};
      end
      c_size_half: begin
        w_be    = 8'h03 << {Dmem_addr[2:1], 1'b0};
        w_wdata = {4{Dmem_data[15:0]}};
      end
      c_size_word: begin
        w_be    = 8'h0F << {Dmem_addr[2], 2'b00};
        w_wdata = {2{Dmem_data[31:0]}};
      end
      default: begin
        w_be    = 8'hFF;
        w_wdata = Dmem_data;
      end
    endcase
  end

  // Store merge into the backing store at the accepting edge.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_store) begin
      for (int b = 0; b < 8; b++) begin
        if (w_be[b]) begin
          r_mem[w_line_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Queue payload: new slot written at the tail, every other countdown ticks down.
  always_ff @(posedge clock) begin
    for (int i = 0; i < c_depth; i++) begin
      if (w_push && (r_wr_ptr == 4'(i))) begin
        r_fifo_tag[i]  <= r_next_tag;
        r_fifo_data[i] <= w_rd_line;
        r_fifo_cd[i]   <= c_cd_init;
      end else begin
        r_fifo_cd[i]   <= r_fifo_cd[i] - 4'd1;
      end
    end
  end

  // Transaction state: tag counter, queue pointers and held-tag bitmap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_next_tag <= 4'd1;
      r_wr_ptr   <= 4'd0;
      r_rd_ptr   <= 4'd0;
      r_count    <= 4'd0;
      r_held     <= 16'd0;
    end else begin
      if (w_accept) begin
        r_next_tag <= (r_next_tag == 4'd15) ? 4'd1 : r_next_tag + 4'd1;
      end
      if (w_push) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      r_held <= (r_held | w_push_mask) & ~w_pop_mask;
    end
  end

  // Return register: one-cycle tag/data pulse per expiring load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ret_tag  <= 4'd0;
      r_ret_data <= 64'd0;
    end else if (w_direct) begin
      r_ret_tag  <= r_next_tag;
      r_ret_data <= w_rd_line;
    end else if (w_pop) begin
      r_ret_tag  <= r_fifo_tag[r_rd_ptr];
      r_ret_data <= r_fifo_data[r_rd_ptr];
    end else begin
      r_ret_tag  <= 4'd0;
      r_ret_data <= 64'd0;
    end
  end

  assign mem2proc_tag  = r_ret_tag;
  assign mem2proc_data = r_ret_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_tag_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_tag_responder
// Brief    : Directed bench for mem_tag_responder with a transaction-level
//            reference model (byte-lane memory, due-cycle return queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_tag_responder;

  localparam int         LAT   = 4;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] RSVD  = 2'd3;
  localparam logic [1:0] SZ_B  = 2'd0;
  localparam logic [1:0] SZ_H  = 2'd1;
  localparam logic [1:0] SZ_W  = 2'd2;
  localparam logic [1:0] SZ_D  = 2'd3;
`ifdef MEM_RESP_STALL_EN
  localparam bit STALL_MODEL = 1'b1;
`else
  localparam bit STALL_MODEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd;
  logic [15:0] addr;
  logic [1:0]  size;
  logic [63:0] wdata;
  logic [3:0]  resp;
  logic [63:0] rdata;
  logic [3:0]  rtag;

  always #5 clk = ~clk;

  mem_tag_responder #(.MEM_LINES(8192), .LATENCY(LAT)) dut (
    .clock             (clk),
    .reset             (rst_n),
    .Dmem_command      (cmd),
    .Dmem_addr         (addr),
    .Dmem_size         (size),
    .Dmem_data         (wdata),
    .mem2proc_response (resp),
    .mem2proc_data     (rdata),
    .mem2proc_tag      (rtag)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Cycles since the last reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        q[$];
  logic [3:0]  m_tag = 4'd1;
  logic [63:0] mem_m [0:8191];
  logic [63:0] seen_data [16];
  int          seen_cyc  [16];
  int          ret_total = 0;

  function automatic void store_model(input logic [15:0] a, input logic [1:0] s, input logic [63:0] d);
    int n;
    int lo;
    int base;
    logic [63:0] line;
    n    = 1 << int'(s);
    lo   = int'(a[2:0]);
    base = lo - (lo % n);
    line = mem_m[a[15:3]];
    for (int k = 0; k < n; k++) line[(base + k)*8 +: 8] = d[k*8 +: 8];
    mem_m[a[15:3]] = line;
  endfunction

  always @(negedge clk) begin
    logic [3:0]  e_tag;
    logic [63:0] e_data;
    logic [3:0]  e_resp;
    bit          held;
    bit          acc;
    if (!rst_n) begin
      chk("rst_response", 64'(resp), 64'd0);
      chk("rst_tag", 64'(rtag), 64'd0);
      chk("rst_data", rdata, 64'd0);
      q.delete();
      m_tag = 4'd1;
    end else begin
      e_tag  = 4'd0;
      e_data = 64'd0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_tag  = q[0].tag;
        e_data = q[0].data;
        void'(q.pop_front());
      end
      chk("ret_tag", 64'(rtag), 64'(e_tag));
      chk("ret_data", rdata, e_data);
      if (rtag != 4'd0) begin
        seen_data[rtag] = rdata;
        seen_cyc[rtag]  = cyc;
        ret_total++;
      end
      held = 1'b0;
      foreach (q[i]) if (q[i].tag == m_tag) held = 1'b1;
      acc    = (cmd == LOAD || cmd == STORE) && !held && !(STALL_MODEL && (cyc % 4 == 3));
      e_resp = acc ? m_tag : 4'd0;
      chk("response", 64'(resp), 64'(e_resp));
      if (acc) begin
        if (cmd == LOAD) q.push_back('{cyc + LAT, m_tag, mem_m[addr[15:3]]});
        else             store_model(addr, size, wdata);
        m_tag = (m_tag == 4'd15) ? 4'd1 : m_tag + 4'd1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [1:0] s,
                       input logic [63:0] d, output logic [3:0] r, output int at);
    cmd = c; addr = a; size = s; wdata = d;
    @(negedge clk);
    r  = resp;
    at = cyc;
    @(posedge clk);
    #1;
    cmd = NONE;
  endtask

  task automatic req(input logic [1:0] c, input logic [15:0] a, input logic [1:0] s,
                     input logic [63:0] d, output logic [3:0] r, output int at);
    int tries;
    tries = 0;
    r     = 4'd0;
    at    = 0;
    while (r == 4'd0 && tries < 8) begin
      issue(c, a, s, d, r, at);
      tries++;
    end
    if (r == 4'd0) begin
      n_total++;
      $display("FAIL req_accept: response 0 after 8 tries, required nonzero (cycle %0d)", cyc);
    end
  endtask

  task automatic idle(input int n);
    logic [3:0] r;
    int at;
    for (int i = 0; i < n; i++) issue(NONE, 16'h0, SZ_B, 64'h0, r, at);
  endtask

  logic [15:0] burst_addr [4] = '{16'h0040, 16'h0080, 16'h0100, 16'h0200};
  int exp_burst [15] = '{14, 15, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
`ifdef MEM_RESP_STALL_EN
  int exp_hold [12] = '{1, 2, 3, 0, 4, 5, 6, 0, 7, 8, 9, 0};
`else
  int exp_hold [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
`endif

  initial begin
    logic [3:0] r;
    int at;
    int at2;
    int base;
    foreach (mem_m[i]) mem_m[i] = 64'd0;
    foreach (seen_cyc[i]) begin seen_cyc[i] = -1; seen_data[i] = 64'd0; end
    rst_n = 1'b0; cmd = NONE; addr = 16'h0; size = SZ_B; wdata = 64'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    req(STORE, 16'h0040, SZ_D, 64'h1122334455667788, r, at);
    chk("first_tag", 64'(r), 64'd1);
    req(LOAD, 16'h0040, SZ_D, 64'h0, r, at);
    chk("load_tag", 64'(r), 64'd2);
    idle(LAT + 1);
    chk("load_data", seen_data[2], 64'h1122334455667788);
    chk("load_latency", 64'(seen_cyc[2]), 64'(at + 4));

    req(STORE, 16'h0080, SZ_D, 64'h0, r, at);
    req(STORE, 16'h0083, SZ_B, 64'hAB, r, at);
    req(LOAD, 16'h0080, SZ_B, 64'h0, r, at);
    chk("byte_tag", 64'(r), 64'd5);
    idle(LAT + 1);
    chk("byte_merge", seen_data[5], 64'h00000000AB000000);

    req(STORE, 16'h0085, SZ_H, 64'hFFFF_BEEF, r, at);
    req(STORE, 16'h0082, SZ_W, 64'h1234_5678_CAFE_F00D, r, at);
    req(LOAD, 16'h0080, SZ_W, 64'h0, r, at);
    idle(LAT + 1);
    chk("half_word_merge", seen_data[8], 64'h0000BEEFCAFEF00D);

    req(STORE, 16'h0100, SZ_D, 64'h5, r, at);
    req(LOAD, 16'h0100, SZ_D, 64'h0, r, at);
    req(STORE, 16'h0100, SZ_D, 64'h9, r, at);
    req(LOAD, 16'h0100, SZ_D, 64'h0, r, at);
    idle(LAT + 1);
    chk("snapshot_old", seen_data[10], 64'h5);
    chk("snapshot_new", seen_data[12], 64'h9);

    issue(RSVD, 16'h0040, SZ_D, 64'h0, r, at);
    chk("reserved_cmd", 64'(r), 64'd0);
    req(STORE, 16'h0200, SZ_D, 64'hA5A5A5A55A5A5A5A, r, at);

    base = ret_total;
    for (int i = 0; i < 15; i++) begin
      req(LOAD, burst_addr[i % 4], SZ_D, 64'h0, r, at);
      chk($sformatf("burst_resp%0d", i), 64'(r), 64'(exp_burst[i]));
    end
    idle(LAT + 2);
    chk("burst_returns", 64'(ret_total - base), 64'd15);

    req(LOAD, 16'h0040, SZ_D, 64'h0, r, at);
    req(LOAD, 16'h0080, SZ_D, 64'h0, r, at2);
    rst_n = 1'b0;
    base  = ret_total;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    chk("inflight_dropped", 64'(ret_total), 64'(base));

    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(LOAD, 16'h0040, SZ_D, 64'h0, r, at);
      chk($sformatf("hold_resp%0d", i), 64'(r), 64'(exp_hold[i]));
    end
    idle(LAT + 2);
    chk("post_reset_data", seen_data[1], 64'h1122334455667788);
    chk("post_reset_latency", 64'(seen_cyc[1]), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
